vga_frame_reader: RTL and testbench
===================================

Name: vga_frame_reader

Overview:
- Display-side consumer of the 160x120 RGB332 frame buffer that the capture/downsampler stage writes through DATARAMIN/ADDRRAMIN/regW.
- Generates 640x480@60 VGA timing from the 25 MHz pixel clock. Issues read addresses to the buffer's read port, upscales each stored pixel 4x4, and drives sync plus RGB332 to the DAC pins.
- Sits between the frame-buffer read port and the board VGA connector.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
IMG_W, 160, stored image width
IMG_H, 120, stored image height
SCALE_SHIFT, 2, log2 upscale factor (4x)
ADDR_W, 15, frame-buffer address width
RAM_LAT, 1, read latency of buffer port in clocks (1..3)

Ports:
pl  input  1  25 MHz pixel clock, all logic on rising edge
async_reset  input  1  asynchronous, active-low reset
en  input  1  display enable; 0 forces black, timing keeps running
DATARAMOUT  input  8  RGB332 pixel from buffer read port, valid RAM_LAT clocks after address
ADDRRAMOUT  output  ADDR_W  buffer read address
HSYNC  output  1  horizontal sync, active-low
VSYNC_OUT  output  1  vertical sync, active-low
R  output  3  red
G  output  3  green
B  output  2  blue
frame_start  output  1  one-clock pulse at h=0,v=0 (pre-pipeline)

Behaviour:
- Reset (async_reset=0): h_cnt=0, v_cnt=0, ADDRRAMOUT=0, HSYNC=1, VSYNC_OUT=1, R=G=B=0, frame_start=0, all pipeline stages cleared to "blank, syncs inactive". Takes effect immediately, not at a clock edge. Release is synchronous-safe: first count after release is h=0,v=0.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (H_TOTAL=800). At wrap it returns to 0 and v_cnt increments.
  - v_cnt runs 0..V_TOTAL-1 (525) and wraps to 0.
  - h/v wrap on the same clock is legal: v_cnt wraps and h_cnt returns to 0 together.
- Sync decode, stage 0:
  - hsync_n=0 when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync_n=0 when 490 <= v_cnt < 492.
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- Address: x=h_cnt>>SCALE_SHIFT, y=v_cnt>>SCALE_SHIFT.
  - ADDRRAMOUT = y*IMG_W + x, registered.
  - For IMG_W=160, y*160 is computed as (y<<7)+(y<<5); no multiplier.
  - Width truncated to ADDR_W. Maximum in-image value is 19199, which fits 15 bits.
  - Outside active region ADDRRAMOUT holds 0. Only reads are issued; there is no write port.
- in_img = active && x<IMG_W && y<IMG_H. This is always true for the default parameters; the check is kept for other sizes.
- Alignment: hsync_n, vsync_n and in_img pass through a delay line of 1+RAM_LAT registers, so they emerge on the same clock as DATARAMOUT for that address.
  - Total pin latency from counter value to HSYNC/VSYNC_OUT/RGB = 1+RAM_LAT clocks. It is identical for syncs and colour, so relative timing is exact.
- Colour output register:
  - If delayed in_img && en: R=DATARAMOUT[7:5], G=DATARAMOUT[4:2], B=DATARAMOUT[1:0].
  - Otherwise R=G=B=0.
  - Blanking always forces black regardless of DATARAMOUT.
- frame_start pulses for exactly one clock each time h_cnt=0 && v_cnt=0. It is not delayed; it serves as a capture-side arbitration hint.
- en deassert mid-frame: syncs continue unchanged and RGB goes black within 1+RAM_LAT clocks. Re-assert resumes without resync.
- Reset mid-line: outputs jump to reset values at once. Timing restarts from h=0,v=0 with no partial pulse carried over.

Test Plan:
- Release reset, en=1, run 2 frames -> HSYNC low for exactly 96 clocks every 800. VSYNC_OUT low for exactly 2 lines (1600 clocks) every 525 lines. frame_start period = 420000 clocks.
- Model RAM returning DATARAMOUT=addr[7:0] with RAM_LAT=1 -> pixel (h=5,v=9) shows R,G,B from address 2*160+1=321 (0x41 -> R=2,G=0,B=1). The same value is held over the 4x4 block h 4..7, v 8..11.
- Last pixel h=639,v=479 -> ADDRRAMOUT=19199. At h=640 RGB=0 within 2 clocks even with DATARAMOUT=0xFF.
- Drive en=0 from line 100 to line 200 -> RGB=0 on those lines. Sync waveforms are bit-identical to the en=1 run.
- Assert async_reset low at h=300,v=250 between clock edges -> HSYNC=VSYNC_OUT=1 and RGB=0 immediately. After release, the first HSYNC falling edge comes 656+1+RAM_LAT clocks later.
- RAM_LAT=3 rebuild -> syncs and colour both delayed by 4 clocks; the pixel-to-address mapping from the second scenario still holds.

Source files
------------

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - 640x480@60 VGA scan-out of a 160x120 RGB332 frame buffer with 4x4 upscale
//
// Purpose: generates VGA timing from the pixel clock, issues read addresses to the
// frame-buffer read port and drives sync plus RGB332 to the DAC pins.
//
// Ports:
//   pl          - pixel clock, all logic on the rising edge
//   async_reset - asynchronous active-low reset
//   en          - display enable; low blanks colour, timing keeps running
//   DATARAMOUT  - RGB332 pixel from the buffer, valid RAM_LAT clocks after its address
//   ADDRRAMOUT  - registered buffer read address (0 outside the image)
//   HSYNC       - horizontal sync, active-low
//   VSYNC_OUT   - vertical sync, active-low
//   R, G, B     - colour to the DAC (3/3/2 bits)
//   frame_start - one-clock pulse while h_cnt=0, v_cnt=0 (not pipeline-delayed)
`timescale 1ns/1ps

module vga_frame_reader #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15,
    parameter int RAM_LAT     = 1
) (
    input  logic              pl,
    input  logic              async_reset,
    input  logic              en,
    input  logic [7:0]        DATARAMOUT,
    output logic [ADDR_W-1:0] ADDRRAMOUT,
    output logic              HSYNC,
    output logic              VSYNC_OUT,
    output logic [2:0]        R,
    output logic [2:0]        G,
    output logic [1:0]        B,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    // One stage for the address register plus RAM_LAT stages for the buffer read.
    localparam int DEPTH   = 1 + RAM_LAT;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] IMG_W_H = HW'(IMG_W);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] IMG_H_V = VW'(IMG_H);

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [HW-1:0]     x;
    logic [VW-1:0]     y;
    logic [ADDR_W-1:0] x_a;
    logic [ADDR_W-1:0] y_a;
    logic [ADDR_W-1:0] addr_calc;
    logic              active;
    logic              in_img;
    logic              hs_n;
    logic              vs_n;
    logic [DEPTH-1:0]  hs_pipe;
    logic [DEPTH-1:0]  vs_pipe;
    logic [DEPTH-1:0]  img_pipe;

    // Raster counters; h and v may wrap on the same clock at end of frame.
    always_ff @(posedge pl or negedge async_reset) begin
        if (!async_reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + 1'b1;
            end
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Stage 0 decode straight from the counters.
    assign x   = h_cnt >> SCALE_SHIFT;
    assign y   = v_cnt >> SCALE_SHIFT;
    assign x_a = ADDR_W'(x);
    assign y_a = ADDR_W'(y);

    always_comb begin
        hs_n   = 1'b1;
        vs_n   = 1'b1;
        active = 1'b0;
        in_img = 1'b0;
        if ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) begin
            hs_n = 1'b0;
        end
        if ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) begin
            vs_n = 1'b0;
        end
        active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        in_img = active && (x < IMG_W_H) && (y < IMG_H_V);
    end

    // Row offset y*IMG_W; the 160-wide case is two shifts and an add.
    generate
        if (IMG_W == 160) begin : g_addr_shift
            assign addr_calc = (y_a << 7) + (y_a << 5) + x_a;
        end else begin : g_addr_mul
            assign addr_calc = y_a * ADDR_W'(IMG_W) + x_a;
        end
    endgenerate

    // Address register and the sync/in_img delay line that lines them up with
    // DATARAMOUT. Reset leaves every stage blank with syncs inactive.
    always_ff @(posedge pl or negedge async_reset) begin
        if (!async_reset) begin
            ADDRRAMOUT <= '0;
            hs_pipe    <= '1;
            vs_pipe    <= '1;
            img_pipe   <= '0;
        end else begin
            ADDRRAMOUT <= in_img ? addr_calc : '0;
            hs_pipe    <= {hs_pipe[DEPTH-2:0], hs_n};
            vs_pipe    <= {vs_pipe[DEPTH-2:0], vs_n};
            img_pipe   <= {img_pipe[DEPTH-2:0], in_img};
        end
    end

    assign HSYNC     = hs_pipe[DEPTH-1];
    assign VSYNC_OUT = vs_pipe[DEPTH-1];

    // Colour is gated from the last aligned stage rather than re-registered, so
    // syncs and colour share the same 1+RAM_LAT latency and reset blanks at once.
    always_comb begin
        R = '0;
        G = '0;
        B = '0;
        if (img_pipe[DEPTH-1] && en) begin
            R = DATARAMOUT[7:5];
            G = DATARAMOUT[4:2];
            B = DATARAMOUT[1:0];
        end
    end

    // Qualified by reset so it stays low while reset is held at h=0,v=0.
    assign frame_start = async_reset && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - directed self-checking bench for vga_frame_reader
`timescale 1ns/1ps

module tb_vga_frame_reader;

    localparam int S_HT    = 56;
    localparam int S_VT    = 39;
    localparam int S_FRAME = S_HT * S_VT;

    // Directed vectors for the full-size instances, sorted by edge number.
    // sel: 0 F colour, 1 L3 colour, 2 F address, 3 F HSYNC, 4 L3 HSYNC
    localparam int N_VEC = 20;
    localparam int TK [N_VEC] = '{657, 658, 659, 660, 753, 754, 755, 756, 1457, 1458,
                                  6405, 6406, 6410, 6412, 7206, 7207, 7209, 8809, 8811, 10240};
    localparam int TS [N_VEC] = '{3, 3, 4, 4, 3, 3, 4, 4, 3, 3,
                                  0, 0, 0, 1, 2, 0, 1, 0, 1, 2};
    localparam int TE [N_VEC] = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 0,
                                  'h40, 'h41, 'h42, 'h42, 321, 'h41, 'h41, 'h41, 'h41, 639};

    logic pl;
    logic rst_f, rst_s, en_f, en_s, force_ff;
    int   checks, errors;
    int   edges_f, edges_s;

    logic [14:0] addr_f, addr_3, addr_s;
    logic        hs_f, hs_3, hs_s, vs_f, vs_3, vs_s, fs_f, fs_3, fs_s;
    logic [2:0]  r_f, g_f, r_3, g_3, r_s, g_s;
    logic [1:0]  b_f, b_3, b_s;
    logic [7:0]  data_f, data_3, data_s, pipe_f, pipe_s;
    logic [7:0]  p3 [3];

    vga_frame_reader u_f (
        .pl(pl), .async_reset(rst_f), .en(en_f), .DATARAMOUT(data_f), .ADDRRAMOUT(addr_f),
        .HSYNC(hs_f), .VSYNC_OUT(vs_f), .R(r_f), .G(g_f), .B(b_f), .frame_start(fs_f));

    vga_frame_reader #(.RAM_LAT(3)) u_l3 (
        .pl(pl), .async_reset(rst_f), .en(en_f), .DATARAMOUT(data_3), .ADDRRAMOUT(addr_3),
        .HSYNC(hs_3), .VSYNC_OUT(vs_3), .R(r_3), .G(g_3), .B(b_3), .frame_start(fs_3));

    vga_frame_reader #(.H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
                       .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(3),
                       .IMG_W(10), .IMG_H(8), .RAM_LAT(1)) u_s (
        .pl(pl), .async_reset(rst_s), .en(en_s), .DATARAMOUT(data_s), .ADDRRAMOUT(addr_s),
        .HSYNC(hs_s), .VSYNC_OUT(vs_s), .R(r_s), .G(g_s), .B(b_s), .frame_start(fs_s));

    initial pl = 1'b0;
    always #5 pl = ~pl;

    // Buffer models: each returns the low byte of the address it was given.
    always @(posedge pl) begin
        pipe_f <= addr_f[7:0];
        pipe_s <= addr_s[7:0];
        p3[0]  <= addr_3[7:0];
        p3[1]  <= p3[0];
        p3[2]  <= p3[1];
    end
    assign data_f = force_ff ? 8'hFF : pipe_f;
    assign data_3 = p3[2];
    assign data_s = pipe_s;

    always @(posedge pl or negedge rst_f) begin
        if (!rst_f) edges_f <= 0;
        else        edges_f <= edges_f + 1;
    end
    always @(posedge pl or negedge rst_s) begin
        if (!rst_s) edges_s <= 0;
        else        edges_s <= edges_s + 1;
    end

    task automatic goto_f(input int k);
        int guard = 0;
        while (edges_f < k && guard < 100000) begin
            @(posedge pl); #1;
            guard++;
        end
        if (edges_f != k) begin
            checks++; errors++;
            $display("FAIL goto_f: at edge %0d, required edge %0d", edges_f, k);
        end
    endtask

    task automatic goto_s(input int k);
        int guard = 0;
        while (edges_s < k && guard < 100000) begin
            @(posedge pl); #1;
            guard++;
        end
        if (edges_s != k) begin
            checks++; errors++;
            $display("FAIL goto_s: at edge %0d, required edge %0d", edges_s, k);
        end
    endtask

    task automatic test_reset();
        rst_f = 1'b0; rst_s = 1'b0; en_f = 1'b1; en_s = 1'b1; force_ff = 1'b0;
        repeat (3) @(posedge pl);
        #1;
        checks++; if (hs_f !== 1'b1) begin errors++; $display("FAIL reset_hsync_f: got %b required 1", hs_f); end
        checks++; if (vs_f !== 1'b1) begin errors++; $display("FAIL reset_vsync_f: got %b required 1", vs_f); end
        checks++; if ({r_f, g_f, b_f} !== 8'h00) begin errors++; $display("FAIL reset_rgb_f: got %h required 00", {r_f, g_f, b_f}); end
        checks++; if (addr_f !== 15'd0) begin errors++; $display("FAIL reset_addr_f: got %0d required 0", addr_f); end
        checks++; if (fs_f !== 1'b0) begin errors++; $display("FAIL reset_fs_f: got %b required 0", fs_f); end
        checks++; if (hs_3 !== 1'b1 || vs_3 !== 1'b1) begin errors++; $display("FAIL reset_sync_l3: got %b%b required 11", hs_3, vs_3); end
        checks++; if (hs_s !== 1'b1 || addr_s !== 15'd0) begin errors++; $display("FAIL reset_s: got hs %b addr %0d required 1 0", hs_s, addr_s); end
        @(negedge pl); rst_f = 1'b1; #1;
    endtask

    task automatic test_frame_start();
        checks++; if (fs_f !== 1'b1) begin errors++; $display("FAIL fs_first_f: got %b required 1", fs_f); end
        checks++; if (fs_3 !== 1'b1) begin errors++; $display("FAIL fs_first_l3: got %b required 1", fs_3); end
        goto_f(1);
        checks++; if (fs_f !== 1'b0) begin errors++; $display("FAIL fs_second_f: got %b required 0", fs_f); end
        checks++; if (hs_f !== 1'b1) begin errors++; $display("FAIL hs_start_f: got %b required 1", hs_f); end
    endtask

    task automatic test_line_end();
        goto_f(640);
        checks++; if (addr_f !== 15'd159) begin errors++; $display("FAIL addr_last_col: got %0d required 159", addr_f); end
        force_ff = 1'b1;
        goto_f(641);
        checks++; if ({r_f, g_f, b_f} !== 8'hFF) begin errors++; $display("FAIL rgb_last_col: got %h required ff", {r_f, g_f, b_f}); end
        checks++; if (addr_f !== 15'd0) begin errors++; $display("FAIL addr_blank: got %0d required 0", addr_f); end
        goto_f(642);
        checks++; if ({r_f, g_f, b_f} !== 8'h00) begin errors++; $display("FAIL rgb_h640_blank: got %h required 00", {r_f, g_f, b_f}); end
        force_ff = 1'b0;
    endtask

    task automatic test_sync_and_pixel_map();
        int got;
        for (int i = 0; i < N_VEC; i++) begin
            goto_f(TK[i]);
            case (TS[i])
                0:       got = {24'd0, r_f, g_f, b_f};
                1:       got = {24'd0, r_3, g_3, b_3};
                2:       got = {17'd0, addr_f};
                3:       got = {31'd0, hs_f};
                default: got = {31'd0, hs_3};
            endcase
            checks++;
            if (got !== TE[i]) begin
                errors++;
                $display("FAIL map[%0d] sel %0d edge %0d: got %0d required %0d", i, TS[i], TK[i], got, TE[i]);
            end
        end
    endtask

    task automatic test_small_model();
        int h, v, c, a;
        logic [7:0]  exp_rgb;
        logic [14:0] exp_addr;
        logic        exp_hs, exp_vs, exp_fs;
        @(negedge pl); rst_s = 1'b1; #1;
        for (int k = 0; k <= 2 * S_FRAME + 32; k++) begin
            en_s = !((k >= S_FRAME + 10 * S_HT) && (k < S_FRAME + 21 * S_HT));
            goto_s(k);
            exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 8'h00; exp_addr = 15'd0;
            exp_fs = ((k % S_FRAME) == 0);
            if (k >= 2) begin
                c = k - 2; h = c % S_HT; v = (c / S_HT) % S_VT;
                exp_hs = !(h >= 44 && h < 52);
                exp_vs = !(v >= 34 && v < 36);
                a = (v / 4) * 10 + h / 4;
                if (h < 40 && v < 32 && en_s) exp_rgb = a[7:0];
            end
            if (k >= 1) begin
                c = k - 1; h = c % S_HT; v = (c / S_HT) % S_VT;
                a = (v / 4) * 10 + h / 4;
                if (h < 40 && v < 32) exp_addr = a[14:0];
            end
            checks++; if (hs_s !== exp_hs) begin errors++; $display("FAIL s_hsync edge %0d: got %b required %b", k, hs_s, exp_hs); end
            checks++; if (vs_s !== exp_vs) begin errors++; $display("FAIL s_vsync edge %0d: got %b required %b", k, vs_s, exp_vs); end
            checks++; if ({r_s, g_s, b_s} !== exp_rgb) begin errors++; $display("FAIL s_rgb edge %0d: got %h required %h", k, {r_s, g_s, b_s}, exp_rgb); end
            checks++; if (addr_s !== exp_addr) begin errors++; $display("FAIL s_addr edge %0d: got %0d required %0d", k, addr_s, exp_addr); end
            checks++; if (fs_s !== exp_fs) begin errors++; $display("FAIL s_fs edge %0d: got %b required %b", k, fs_s, exp_fs); end
        end
        en_s = 1'b1;
    endtask

    task automatic test_reset_midline();
        int k0;
        k0 = (edges_f / 800 + 1) * 800 + 700;
        goto_f(k0);
        checks++; if (hs_f !== 1'b0 || hs_3 !== 1'b0) begin errors++; $display("FAIL pre_reset_hsync: got %b%b required 00", hs_f, hs_3); end
        #2 rst_f = 1'b0;
        #1;
        checks++; if (hs_f !== 1'b1) begin errors++; $display("FAIL mid_reset_hsync_f: got %b required 1", hs_f); end
        checks++; if (vs_f !== 1'b1) begin errors++; $display("FAIL mid_reset_vsync_f: got %b required 1", vs_f); end
        checks++; if ({r_f, g_f, b_f} !== 8'h00) begin errors++; $display("FAIL mid_reset_rgb_f: got %h required 00", {r_f, g_f, b_f}); end
        checks++; if (addr_f !== 15'd0 || fs_f !== 1'b0) begin errors++; $display("FAIL mid_reset_addr_fs: got %0d %b required 0 0", addr_f, fs_f); end
        checks++; if (hs_3 !== 1'b1) begin errors++; $display("FAIL mid_reset_hsync_l3: got %b required 1", hs_3); end
        @(negedge pl); rst_f = 1'b1; #1;
        checks++; if (fs_f !== 1'b1) begin errors++; $display("FAIL restart_fs: got %b required 1", fs_f); end
        goto_f(100);
        checks++; if (hs_f !== 1'b1) begin errors++; $display("FAIL restart_no_partial: got %b required 1", hs_f); end
        goto_f(657);
        checks++; if (hs_f !== 1'b1) begin errors++; $display("FAIL restart_hs657_f: got %b required 1", hs_f); end
        goto_f(658);
        checks++; if (hs_f !== 1'b0) begin errors++; $display("FAIL restart_hs658_f: got %b required 0", hs_f); end
        goto_f(659);
        checks++; if (hs_3 !== 1'b1) begin errors++; $display("FAIL restart_hs659_l3: got %b required 1", hs_3); end
        goto_f(660);
        checks++; if (hs_3 !== 1'b0) begin errors++; $display("FAIL restart_hs660_l3: got %b required 0", hs_3); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_frame_start();
        test_line_end();
        test_sync_and_pixel_map();
        test_small_model();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
